// File: rtl/sop_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// sop_sweep_checker_if
//   Bundle between the sweep checker and its surroundings: the stimulus it
//   drives into the SOP block (x/y/z), the SOP result it reads back (f_in),
//   the sweep request (start) and the status/result outputs.
//
//   slave  : the checker itself (drives x/y/z and results, reads start/f_in)
//   master : the environment (SOP block + controller driving start)
// ---------------------------------------------------------------------------
interface sop_sweep_checker_if;
  logic       start;      // sweep request, sampled only in IDLE
  logic       x;          // stimulus MSB
  logic       y;          // stimulus middle bit
  logic       z;          // stimulus LSB
  logic       f_in;       // SOP block output
  logic       busy;       // high while sweeping
  logic       done;       // one-cycle completion pulse
  logic       pass;       // captured table equals expected mask
  logic [7:0] tt;         // captured truth table, bit i = f at {x,y,z}=i
  logic [3:0] err_count;  // number of mismatching indices, 0..8
  logic [2:0] err_idx;    // lowest mismatching index

  modport slave (
    input  start, f_in,
    output x, y, z, busy, done, pass, tt, err_count, err_idx
  );

  modport master (
    output start, f_in,
    input  x, y, z, busy, done, pass, tt, err_count, err_idx
  );
endinterface

// File: rtl/sop_sweep_checker.sv
// ---------------------------------------------------------------------------
// sop_sweep_checker
//   Self-check stage wrapped around the combinational SOP block
//   F(x,y,z) = xyz + x'z. A start pulse sweeps {x,y,z} through 0..7, holds
//   each vector SETTLE cycles, samples f_in on one further cycle, builds the
//   observed truth table and compares it with EXP_MASK.
//
// Parameters
//   EXP_MASK : expected truth table (bit i = F at {x,y,z}=i)
//   SETTLE   : hold cycles before each sample, 1..255
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   sw    : slave side of sop_sweep_checker_if (start/f_in in; x/y/z, busy,
//           done, pass, tt, err_count, err_idx out, all registered)
// ---------------------------------------------------------------------------
module sop_sweep_checker #(
  parameter logic [7:0]  EXP_MASK = 8'h8A,
  parameter int unsigned SETTLE   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sop_sweep_checker_if.slave sw
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Settle counter terminal value; the counter restarts at 0 for each vector.
  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] xyz_q, xyz_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] tt_q, tt_d;
  logic [3:0] err_count_q, err_count_d;
  logic [2:0] err_idx_q, err_idx_d;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= 8'd0;
      xyz_q       <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tt_q        <= 8'd0;
      err_count_q <= 4'd0;
      err_idx_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      xyz_q       <= xyz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      tt_q        <= tt_d;
      err_count_q <= err_count_d;
      err_idx_q   <= err_idx_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (sw.start) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (idx_q == 3'd7) ? S_DONE : S_SETTLE;
      S_DONE:   state_d = S_IDLE;   // start is ignored here, no queuing
      default:  state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and registered-output next values
  // -------------------------------------------------------------------------
  always_comb begin
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    tt_d        = tt_q;
    err_count_d = err_count_q;
    err_idx_d   = err_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (sw.start) begin
          idx_d       = 3'd0;
          cnt_d       = 8'd0;
          tt_d        = 8'd0;
          err_count_d = 4'd0;
          err_idx_d   = 3'd0;
          pass_d      = 1'b0;
        end
      end

      S_SETTLE: cnt_d = cnt_q + 8'd1;

      S_SAMPLE: begin
        tt_d[idx_q] = sw.f_in;
        if (sw.f_in != EXP_MASK[idx_q]) begin
          err_count_d = err_count_q + 4'd1;
          // A zero count means nothing has failed yet in this sweep.
          if (err_count_q == 4'd0) err_idx_d = idx_q;
        end
        if (idx_q == 3'd7) begin
          // Compare against the table including the bit captured right now,
          // so pass is already valid in the done cycle.
          pass_d = (tt_d == EXP_MASK);
        end else begin
          idx_d = idx_q + 3'd1;
          cnt_d = 8'd0;
        end
      end

      default: ;
    endcase

    // Outputs are derived from the next state so they change on the same
    // edge as the state they describe.
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    xyz_d  = (state_d == S_IDLE) ? 3'd0 : idx_d;
  end

  assign sw.x         = xyz_q[2];
  assign sw.y         = xyz_q[1];
  assign sw.z         = xyz_q[0];
  assign sw.busy      = busy_q;
  assign sw.done      = done_q;
  assign sw.pass      = pass_q;
  assign sw.tt        = tt_q;
  assign sw.err_count = err_count_q;
  assign sw.err_idx   = err_idx_q;

endmodule

// File: tb/tb_sop_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_sop_sweep_checker
//   Two checker instances (SETTLE=1 and SETTLE=3), each wrapped around a
//   behavioural SOP block whose output can be corrupted per vector through a
//   fault mask. Expected results come from the SOP equation and the fault
//   mask using plain arithmetic.
// ---------------------------------------------------------------------------
module tb_sop_sweep_checker;

  localparam logic [7:0] EXP = 8'h8A;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sop_sweep_checker_if sw0 ();
  sop_sweep_checker_if sw1 ();

  sop_sweep_checker #(.EXP_MASK(EXP), .SETTLE(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw0.slave)
  );

  sop_sweep_checker #(.EXP_MASK(EXP), .SETTLE(3)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw1.slave)
  );

  // Behavioural SOP block: F = xyz + x'z, v = {x,y,z}.
  function automatic logic sop_f(input logic [2:0] v);
    return (v[2] & v[1] & v[0]) | (~v[2] & v[0]);
  endfunction

  logic       start_a [2];
  logic [7:0] fault_a [2];
  logic [2:0] vec_o   [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       pass_o  [2];
  logic [7:0] tt_o    [2];
  logic [3:0] ec_o    [2];
  logic [2:0] ei_o    [2];
  int         done_seen [2];
  int         done_base [2];

  assign sw0.start = start_a[0];
  assign sw1.start = start_a[1];
  assign sw0.f_in  = sop_f({sw0.x, sw0.y, sw0.z}) ^ fault_a[0][{sw0.x, sw0.y, sw0.z}];
  assign sw1.f_in  = sop_f({sw1.x, sw1.y, sw1.z}) ^ fault_a[1][{sw1.x, sw1.y, sw1.z}];

  assign vec_o[0]  = {sw0.x, sw0.y, sw0.z};
  assign vec_o[1]  = {sw1.x, sw1.y, sw1.z};
  assign busy_o[0] = sw0.busy;
  assign busy_o[1] = sw1.busy;
  assign done_o[0] = sw0.done;
  assign done_o[1] = sw1.done;
  assign pass_o[0] = sw0.pass;
  assign pass_o[1] = sw1.pass;
  assign tt_o[0]   = sw0.tt;
  assign tt_o[1]   = sw1.tt;
  assign ec_o[0]   = sw0.err_count;
  assign ec_o[1]   = sw1.err_count;
  assign ei_o[0]   = sw0.err_idx;
  assign ei_o[1]   = sw1.err_idx;

  // Counts done pulses seen on each instance.
  always @(negedge clk) begin
    if (done_o[0] === 1'b1) done_seen[0]++;
    if (done_o[1] === 1'b1) done_seen[1]++;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] exp_tt(input logic [7:0] fault);
    logic [7:0] t;
    for (int v = 0; v < 8; v++) t[v] = sop_f(3'(v)) ^ fault[v];
    return t;
  endfunction

  function automatic int exp_ec(input logic [7:0] fault);
    logic [7:0] t;
    int n;
    t = exp_tt(fault);
    n = 0;
    for (int v = 0; v < 8; v++) if (t[v] != EXP[v]) n++;
    return n;
  endfunction

  function automatic int exp_ei(input logic [7:0] fault);
    logic [7:0] t;
    t = exp_tt(fault);
    for (int v = 0; v < 8; v++) if (t[v] != EXP[v]) return v;
    return 0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input int u, input logic [7:0] fault, input string tag);
    check($sformatf("%s_tt", tag),   tt_o[u],   exp_tt(fault));
    check($sformatf("%s_pass", tag), pass_o[u], (exp_tt(fault) == EXP));
    check($sformatf("%s_ec", tag),   ec_o[u],   exp_ec(fault));
    check($sformatf("%s_ei", tag),   ei_o[u],   exp_ei(fault));
  endtask

  task automatic check_reset_vals(input int u, input string tag);
    check($sformatf("%s_vec", tag),  vec_o[u],  0);
    check($sformatf("%s_busy", tag), busy_o[u], 0);
    check($sformatf("%s_done", tag), done_o[u], 0);
    check($sformatf("%s_pass", tag), pass_o[u], 0);
    check($sformatf("%s_tt", tag),   tt_o[u],   0);
    check($sformatf("%s_ec", tag),   ec_o[u],   0);
    check($sformatf("%s_ei", tag),   ei_o[u],   0);
  endtask

  // Raises start for exactly one rising edge (E0); returns at the negedge
  // just after E0.
  task automatic pulse_start(input int u);
    @(negedge clk);
    start_a[u] = 1'b1;
    @(negedge clk);
    start_a[u] = 1'b0;
  endtask

  // Runs one sweep. When do_start is 0 the caller has already produced the
  // accepting edge and we are at the negedge just after it. poke_at >= 0
  // raises start for one edge mid-sweep. Returns at the negedge showing done.
  task automatic sweep(input int u, input int settle, input logic [7:0] fault,
                       input int poke_at, input bit do_start, input string tag);
    int  per, total, n;
    bit  got;
    per   = settle + 1;
    total = 8 * per;
    got   = 1'b0;
    fault_a[u]   = fault;
    done_base[u] = done_seen[u];
    if (do_start) pulse_start(u);
    check($sformatf("%s_cleared_tt", tag), tt_o[u], 0);
    check($sformatf("%s_cleared_ec", tag), ec_o[u], 0);
    check($sformatf("%s_cleared_pass", tag), pass_o[u], 0);
    n = 0;
    while (n <= total + 4) begin
      if (n > 0) @(negedge clk);
      if (done_o[u] === 1'b1) begin
        got = 1'b1;
        break;
      end
      check($sformatf("%s_vec_c%0d", tag, n), vec_o[u], n / per);
      check($sformatf("%s_busy_c%0d", tag, n), busy_o[u], 1);
      start_a[u] = (n == poke_at);
      n++;
    end
    start_a[u] = 1'b0;
    check($sformatf("%s_done_seen", tag), got, 1);
    check($sformatf("%s_done_cycle", tag), n, total);
    check($sformatf("%s_busy_at_done", tag), busy_o[u], 0);
    check_results(u, fault, tag);
  endtask

  // Cycle after done: start optionally held (must be ignored), done pulse
  // must be single, results must hold.
  task automatic after_done(input int u, input logic [7:0] fault, input bit poke, input string tag);
    start_a[u] = poke;
    @(negedge clk);
    #1;
    check($sformatf("%s_done_low", tag), done_o[u], 0);
    check($sformatf("%s_ignored_busy", tag), busy_o[u], 0);
    check($sformatf("%s_one_done", tag), done_seen[u], done_base[u] + 1);
    check_results(u, fault, $sformatf("%s_hold", tag));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] f;
    start_a[0] = 1'b0;  start_a[1] = 1'b0;
    fault_a[0] = 8'h00; fault_a[1] = 8'h00;
    done_seen[0] = 0;   done_seen[1] = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_vals(0, "rst0");
    check_reset_vals(1, "rst1");
    #2 rst_n = 1'b1;

    // Correct SOP, SETTLE=1: 16 cycles, tt=8A, pass.
    sweep(0, 1, 8'h00, -1, 1'b1, "good");
    after_done(0, 8'h00, 1'b0, "good");

    // f_in tied 0: corrupting exactly the ones of F gives a constant 0.
    sweep(0, 1, EXP, -1, 1'b1, "tie0");
    after_done(0, EXP, 1'b0, "tie0");

    // f_in = ~F: all eight mismatch, err_count must read 8.
    sweep(0, 1, 8'hFF, -1, 1'b1, "inv");
    after_done(0, 8'hFF, 1'b0, "inv");

    // Random single-sweep corruption patterns.
    for (int r = 0; r < 4; r++) begin
      f = 8'($urandom_range(0, 255));
      sweep(0, 1, f, -1, 1'b1, $sformatf("rnd%0d", r));
      after_done(0, f, 1'b0, $sformatf("rnd%0d", r));
    end

    // Start re-pulsed mid-sweep and during DONE: ignored.
    sweep(0, 1, 8'h00, 5, 1'b1, "poke");
    after_done(0, 8'h00, 1'b1, "poke");
    // start still high at the first IDLE edge: accepted, results cleared.
    @(negedge clk);
    start_a[0] = 1'b0;
    check("b2b_busy", busy_o[0], 1);
    f = 8'($urandom_range(1, 255));
    sweep(0, 1, f, -1, 1'b0, "b2b");
    after_done(0, f, 1'b0, "b2b");

    // Reset at cycle 7 of a sweep: immediate abort, no done pulse.
    fault_a[0]   = 8'hFF;
    done_base[0] = done_seen[0];
    pulse_start(0);
    repeat (7) @(negedge clk);
    check("pre_rst_ec", (ec_o[0] != 4'd0), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals(0, "midrst");
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_seen[0], done_base[0]);
    #2 rst_n = 1'b1;
    sweep(0, 1, 8'h00, -1, 1'b1, "postrst");
    after_done(0, 8'h00, 1'b0, "postrst");

    // SETTLE=3: each vector held 4 cycles, done at cycle 32.
    sweep(1, 3, 8'h00, -1, 1'b1, "s3good");
    after_done(1, 8'h00, 1'b0, "s3good");
    f = 8'($urandom_range(1, 255));
    sweep(1, 3, f, -1, 1'b1, "s3rnd");
    after_done(1, f, 1'b0, "s3rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
